// File: rtl/dotmatrix_pkg.sv
// dotmatrix_pkg: shared link constants and row-select decode helper
package dotmatrix_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int ROW_W = 4;
  localparam int COLS_PER_LE = 16;
  localparam int CNT_W = 5;
  typedef struct packed {
    logic             ok;
    logic [ROW_W-1:0] idx;
  } row_sel_t;
  function automatic row_sel_t find_zero(input logic [ROWS-1:0] v);
    int n;
    find_zero = '0;
    n = 0;
    for (int i = 0; i < ROWS; i++)
      if (!v[i]) begin
        n++;
        find_zero.idx = ROW_W'(i);
      end
    find_zero.ok = (n == 1);
  endfunction
endpackage

// File: rtl/dm_edge_sync.sv
// dm_edge_sync: SYNC_STAGES synchroniser plus rising-edge detect; ports clk, reset(low), i_d -> o_lvl, o_rise
module dm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise
);
  logic r_prev;
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign o_lvl = i_d;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk)
        r_sync <= !reset ? '0 : SYNC_STAGES'({r_sync, i_d});
      assign o_lvl = r_sync[SYNC_STAGES-1];
    end
  endgenerate
  always_ff @(posedge clk)
    r_prev <= !reset ? 1'b0 : o_lvl;
  assign o_rise = o_lvl & ~r_prev;
endmodule

// File: rtl/dotmatrix_rx.sv
// dotmatrix_rx: decodes row/column shift + latch stream into a 16x16 frame buffer; rd_row/rd_data read port, row_wr/wr_row/frame_done write status, blank, sticky err_bits/err_row with err_clr
module dotmatrix_rx
  import dotmatrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ROW_SWAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rclk,
  input  logic             rsdi,
  input  logic             cclk,
  input  logic             csdi,
  input  logic             le,
  input  logic             oeb,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data,
  output logic             row_wr,
  output logic [ROW_W-1:0] wr_row,
  output logic             frame_done,
  output logic             blank,
  output logic             err_bits,
  output logic             err_row,
  input  logic             err_clr
);
  logic [5:0] w_in, w_lvl, w_rise;
  logic [COLS-1:0] r_fb [ROWS];
  logic [ROWS-1:0] r_row_sr, w_row_n;
  logic [COLS-1:0] r_col_sr, w_col_n;
  logic [CNT_W-1:0] r_ccnt, w_cnt_n;
  row_sel_t w_sel;
  logic [ROW_W-1:0] w_phys;
  logic w_bad_bits, w_bad_row, w_wr, w_unused;
  assign w_in = {oeb, le, csdi, cclk, rsdi, rclk};
  genvar i;
  for (i = 0; i < 6; i++) begin : g_in
    dm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset(reset), .i_d(w_in[i]), .o_lvl(w_lvl[i]), .o_rise(w_rise[i])
    );
  end
  assign w_unused = ^{w_rise[1], w_rise[3], w_rise[5]};
  assign blank = w_lvl[5];
  // le decode sees the register values after any shift landing in the same cycle
  always_comb begin
    w_row_n = w_rise[0] ? {r_row_sr[ROWS-2:0], w_lvl[1]} : r_row_sr;
    w_col_n = w_rise[2] ? {r_col_sr[COLS-2:0], w_lvl[3]} : r_col_sr;
    w_cnt_n = (w_rise[2] && r_ccnt != '1) ? r_ccnt + 1'b1 : r_ccnt;
    w_sel = find_zero(w_row_n);
    w_phys = ROW_SWAP ? (w_sel.idx ^ 4'd1) : w_sel.idx;
    w_bad_bits = w_rise[4] && (w_cnt_n != CNT_W'(COLS_PER_LE));
    w_bad_row = w_rise[4] && !w_sel.ok;
    w_wr = w_rise[4] && !w_bad_bits && !w_bad_row;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) r_fb[r] <= '0;
      r_row_sr <= '1;
      r_col_sr <= '0;
      r_ccnt <= '0;
      rd_data <= '0;
      row_wr <= 1'b0;
      wr_row <= '0;
      frame_done <= 1'b0;
      err_bits <= 1'b0;
      err_row <= 1'b0;
    end else begin
      r_row_sr <= w_row_n;
      r_col_sr <= w_col_n;
      r_ccnt <= w_rise[4] ? '0 : w_cnt_n;
      if (w_wr) begin
        r_fb[w_phys] <= w_col_n;
        wr_row <= w_phys;
      end
      row_wr <= w_wr;
      frame_done <= w_wr && (w_phys == 4'd15);
      err_bits <= (err_bits & ~err_clr) | w_bad_bits;
      err_row <= (err_row & ~err_clr) | w_bad_row;
      rd_data <= r_fb[rd_row];
    end
  end
endmodule

// File: tb/tb_dotmatrix_rx.sv
// tb_dotmatrix_rx: table-driven and sequence tests of dotmatrix_rx with a row-write scoreboard
module tb_dotmatrix_rx;
  localparam int SYNC = 2;
  localparam bit SWAP = 1;
  logic clk = 0, reset = 0, rclk = 0, rsdi = 1, cclk = 0, csdi = 0, le = 0, oeb = 0, err_clr = 0;
  logic [3:0] rd_row = 0;
  logic [15:0] rd_data;
  logic row_wr, frame_done, blank, err_bits, err_row;
  logic [3:0] wr_row;
  dotmatrix_rx #(.SYNC_STAGES(SYNC), .ROW_SWAP(SWAP)) dut (
    .clk(clk), .reset(reset), .rclk(rclk), .rsdi(rsdi), .cclk(cclk), .csdi(csdi),
    .le(le), .oeb(oeb), .rd_row(rd_row), .rd_data(rd_data), .row_wr(row_wr),
    .wr_row(wr_row), .frame_done(frame_done), .blank(blank), .err_bits(err_bits),
    .err_row(err_row), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] row;
    logic fd;
  } exp_t;
  typedef struct {
    int nr;
    logic r0;
    int nc;
    logic [15:0] d;
    logic wr;
    logic [3:0] tap;
    logic eb;
    logic er;
  } vec_t;
  exp_t q[$];
  logic [15:0] m_fb [16];
  int checks = 0, errors = 0, fd_cnt = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (reset && row_wr) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row_wr got row %0d want none", wr_row);
      end else begin
        e = q.pop_front();
        chk("wr_row", 32'(wr_row), 32'(e.row));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
      end
      if (frame_done) fd_cnt++;
    end else if (reset && frame_done) chk("fd_without_wr", 32'(frame_done), 0);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rbit(input logic d);
    rsdi = d; tick(2); rclk = 1; tick(2); rclk = 0; tick(2);
  endtask
  task automatic cbit(input logic d);
    csdi = d; tick(2); cclk = 1; tick(2); cclk = 0; tick(2);
  endtask
  task automatic run_row(input int nr, input logic r0, input int nc, input logic [15:0] d,
                         input logic wr, input logic [3:0] tap);
    logic [3:0] p;
    logic [15:0] s;
    p = SWAP ? tap ^ 4'd1 : tap;
    s = d;
    for (int i = 0; i < nr; i++) rbit(i == 0 ? r0 : 1'b1);
    for (int i = 0; i < nc; i++) begin
      cbit(s[15]);
      s = s << 1;
    end
    if (wr) begin
      q.push_back('{p, p == 4'd15});
      m_fb[p] = d;
    end
    le = 1; tick(2); le = 0; tick(8);
    chk("pending_writes", q.size(), 0);
  endtask
  task automatic check_fb(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_row = 4'(i);
      tick(1);
      chk(tag, 32'(rd_data), 32'(m_fb[i]));
    end
  endtask
  task automatic do_reset();
    reset = 0; tick(2); reset = 1;
    q.delete();
    for (int i = 0; i < 16; i++) m_fb[i] = '0;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
  initial begin
    vec_t tv[13];
    tv[0]  = '{1, 1'b0, 16, 16'hA5C3, 1'b1, 4'd0,  1'b0, 1'b0};
    tv[1]  = '{1, 1'b1, 16, 16'h1234, 1'b1, 4'd1,  1'b0, 1'b0};
    tv[2]  = '{1, 1'b1, 15, 16'hFFFF, 1'b0, 4'd2,  1'b1, 1'b0};
    tv[3]  = '{0, 1'b0, 16, 16'hBEEF, 1'b1, 4'd2,  1'b0, 1'b0};
    tv[4]  = '{1, 1'b0, 16, 16'h5555, 1'b0, 4'd0,  1'b0, 1'b1};
    tv[5]  = '{13, 1'b1, 16, 16'h0F0F, 1'b1, 4'd13, 1'b0, 1'b0};
    tv[6]  = '{3, 1'b1, 16, 16'hAAAA, 1'b0, 4'd0,  1'b0, 1'b1};
    tv[7]  = '{1, 1'b0, 17, 16'h1111, 1'b0, 4'd0,  1'b1, 1'b0};
    tv[8]  = '{14, 1'b1, 16, 16'h8001, 1'b1, 4'd14, 1'b0, 1'b0};
    tv[9]  = '{1, 1'b1, 16, 16'h7FFE, 1'b1, 4'd15, 1'b0, 1'b0};
    tv[10] = '{0, 1'b0, 0, 16'h0000, 1'b0, 4'd0,  1'b1, 1'b0};
    tv[11] = '{16, 1'b1, 16, 16'hCAFE, 1'b0, 4'd0,  1'b0, 1'b1};
    tv[12] = '{0, 1'b0, 3, 16'hE000, 1'b0, 4'd0,  1'b1, 1'b1};
    for (int i = 0; i < 16; i++) m_fb[i] = '0;
    tick(3);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_row_wr", 32'(row_wr), 0);
    chk("rst_wr_row", 32'(wr_row), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_err_bits", 32'(err_bits), 0);
    chk("rst_err_row", 32'(err_row), 0);
    reset = 1;
    tick(1);
    check_fb("fb_after_reset");
    oeb = 1; tick(SYNC);
    chk("blank_set", 32'(blank), 1);
    oeb = 0; tick(SYNC);
    chk("blank_clr", 32'(blank), 0);
    for (int i = 0; i < 13; i++) begin
      run_row(tv[i].nr, tv[i].r0, tv[i].nc, tv[i].d, tv[i].wr, tv[i].tap);
      chk($sformatf("vec%0d_err_bits", i), 32'(err_bits), 32'(tv[i].eb));
      chk($sformatf("vec%0d_err_row", i), 32'(err_row), 32'(tv[i].er));
      err_clr = 1; tick(1); err_clr = 0;
      chk($sformatf("vec%0d_clr_bits", i), 32'(err_bits), 0);
      chk($sformatf("vec%0d_clr_row", i), 32'(err_row), 0);
    end
    check_fb("fb_table");
    do_reset();
    fd_cnt = 0;
    for (int r = 0; r < 16; r++) run_row(1, r == 0 ? 1'b0 : 1'b1, 16, 16'h0001 << r, 1'b1, 4'(r));
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_err_bits", 32'(err_bits), 0);
    chk("frame_err_row", 32'(err_row), 0);
    check_fb("fb_frame");
    run_row(0, 1'b0, 15, 16'h0000, 1'b0, 4'd0);
    chk("short_err_bits", 32'(err_bits), 1);
    le = 1; tick(SYNC);
    err_clr = 1; tick(1); err_clr = 0;
    chk("new_err_beats_clr", 32'(err_bits), 1);
    le = 0; tick(4);
    err_clr = 1; tick(1); err_clr = 0;
    chk("clr_after_event", 32'(err_bits), 0);
    check_fb("fb_after_short");
    rbit(1'b0);
    for (int i = 0; i < 8; i++) cbit(1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) cbit(1'b1);
    le = 1; tick(2); le = 0; tick(8);
    chk("midrst_err_row", 32'(err_row), 1);
    chk("midrst_err_bits", 32'(err_bits), 0);
    chk("midrst_pending", q.size(), 0);
    check_fb("fb_midrst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
